// File: rtl/pot_mac_sequencer.sv
// pot_mac_sequencer
// Streams unsigned activation / power-of-two weight pairs through a shift
// multiplier and accumulates a signed dot product of programmable length.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start, length       : command; length sampled with start while idle
//   busy                : high whenever not idle
//   in_valid / in_ready : operand beat handshake, carrying in and weight
//   in                  : unsigned activation
//   weight              : {sign, shift amount} weight code
//   out_valid/out_ready : result handshake
//   out                 : signed accumulated dot product (accumulator register)
module pot_mac_sequencer #(
    parameter int WEIGHT_BIT_WIDTH = 4,
    parameter int INPUT_BIT_WIDTH  = 4,
    parameter int MAX_LENGTH       = 16,
    localparam int PRODUCT_BIT_WIDTH = INPUT_BIT_WIDTH + (2**WEIGHT_BIT_WIDTH) / 2,
    localparam int ACC_BIT_WIDTH     = PRODUCT_BIT_WIDTH + $clog2(MAX_LENGTH),
    localparam int LEN_BIT_WIDTH     = $clog2(MAX_LENGTH + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [LEN_BIT_WIDTH-1:0]        length,
    output logic                            busy,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [INPUT_BIT_WIDTH-1:0]      in,
    input  logic [WEIGHT_BIT_WIDTH-1:0]     weight,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic signed [ACC_BIT_WIDTH-1:0] out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [LEN_BIT_WIDTH-1:0]        cnt_q, cnt_d;
    logic signed [ACC_BIT_WIDTH-1:0] acc_q, acc_d;

    logic [PRODUCT_BIT_WIDTH-1:0]    mag;
    logic signed [ACC_BIT_WIDTH-1:0] prod;

    // Shift result always fits: INPUT_BIT_WIDTH + max shift < PRODUCT_BIT_WIDTH.
    always_comb begin
        mag  = {{(PRODUCT_BIT_WIDTH-INPUT_BIT_WIDTH){1'b0}}, in}
               << weight[WEIGHT_BIT_WIDTH-2:0];
        prod = signed'({{(ACC_BIT_WIDTH-PRODUCT_BIT_WIDTH){1'b0}}, mag});
        if (weight[WEIGHT_BIT_WIDTH-1]) begin
            prod = -prod;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    cnt_d = length;
                    state_d = (length == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    acc_d = acc_q + prod;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == LEN_BIT_WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    // Handshake outputs decode registered state only, so neither ready nor
    // valid depends combinationally on the opposite side of its handshake.
    assign busy      = (state_q != IDLE);
    assign in_ready  = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign out       = acc_q;

endmodule

// File: tb/tb_pot_mac_sequencer.sv
module tb_pot_mac_sequencer;
    localparam int WW  = 4;
    localparam int IW  = 4;
    localparam int ML  = 16;
    localparam int AW  = IW + (2**WW) / 2 + $clog2(ML);
    localparam int LW  = $clog2(ML + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [LW-1:0]        length = '0;
    logic                 busy;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [IW-1:0]        din = '0;
    logic [WW-1:0]        weight = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [AW-1:0] dout;

    int errors = 0;
    int checks = 0;
    int vin[16];
    int vw[16];

    pot_mac_sequencer #(
        .WEIGHT_BIT_WIDTH(WW),
        .INPUT_BIT_WIDTH (IW),
        .MAX_LENGTH      (ML)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .length   (length),
        .busy     (busy),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in       (din),
        .weight   (weight),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: activation times signed power of two.
    function automatic int pot(input int a, input int w);
        int m;
        m = a * (1 << (w % 8));
        return (w >= 8) ? -m : m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise(input bit en);
        out_ready = 1'($urandom);
        if (en) begin
            start  = 1'($urandom);
            length = LW'($urandom_range(16, 0));
        end
    endtask

    task automatic quiet();
        start     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        din       = IW'($urandom);
        weight    = WW'($urandom);
    endtask

    // Runs one vector from vin/vw; entered and left in an IDLE cycle.
    task automatic run_vec(input int len, input int gap_max, input int bp, input bit nz);
        int exp_sum;
        int held;
        exp_sum = 0;
        for (int i = 0; i < len; i++) exp_sum += pot(vin[i], vw[i]);
        chk("idle_busy", int'(busy), 0);
        start  = 1'b1;
        length = LW'(len);
        tick();
        quiet();
        for (int i = 0; i < len; i++) begin
            chk("run_ready", int'(in_ready), 1);
            chk("run_busy", int'(busy), 1);
            chk("run_ovalid", int'(out_valid), 0);
            repeat ($urandom_range(gap_max, 0)) begin
                noise(nz);
                tick();
                quiet();
            end
            noise(nz);
            in_valid = 1'b1;
            din      = IW'(vin[i]);
            weight   = WW'(vw[i]);
            tick();
            quiet();
        end
        chk("done_ovalid", int'(out_valid), 1);
        chk("done_out", int'(dout), exp_sum);
        chk("done_ready", int'(in_ready), 0);
        held = int'(dout);
        repeat (bp) begin
            tick();
            chk("bp_ovalid", int'(out_valid), 1);
            chk("bp_busy", int'(busy), 1);
            chk("bp_out", int'(dout), held);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("after_busy", int'(busy), 0);
        chk("after_ovalid", int'(out_valid), 0);
        chk("after_ready", int'(in_ready), 0);
    endtask

    initial begin
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(in_ready), 0);
        chk("rst_ovalid", int'(out_valid), 0);
        chk("rst_out", int'(dout), 0);
        tick();
        rst = 1'b0;
        tick();

        // basic vector, then same with stalls and backpressure
        vin[0] = 5;  vw[0] = 2;
        vin[1] = 3;  vw[1] = 9;
        vin[2] = 15; vw[2] = 7;
        run_vec(3, 0, 0, 1'b0);
        run_vec(3, 3, 5, 1'b0);

        // extremes
        for (int i = 0; i < 16; i++) begin vin[i] = 15; vw[i] = 7; end
        run_vec(16, 0, 0, 1'b0);
        for (int i = 0; i < 16; i++) begin vin[i] = 15; vw[i] = 15; end
        run_vec(16, 1, 1, 1'b0);
        vin[0] = 7; vw[0] = 8;
        run_vec(1, 0, 0, 1'b0);

        // zero length, then start noise during RUN
        run_vec(0, 0, 2, 1'b0);
        for (int i = 0; i < 16; i++) begin
            vin[i] = $urandom_range(15, 0);
            vw[i]  = $urandom_range(15, 0);
        end
        run_vec(10, 2, 1, 1'b1);

        // reset mid-run after 2 of 4 beats
        start  = 1'b1;
        length = LW'(4);
        tick();
        quiet();
        repeat (2) begin
            in_valid = 1'b1;
            din      = 4'd9;
            weight   = 4'd3;
            tick();
            quiet();
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ready", int'(in_ready), 0);
        chk("mid_rst_ovalid", int'(out_valid), 0);
        chk("mid_rst_out", int'(dout), 0);
        tick();
        rst = 1'b0;
        tick();
        vin[0] = 1; vw[0] = 0;
        run_vec(1, 0, 0, 1'b0);

        // random back-to-back vectors
        for (int v = 0; v < 20; v++) begin
            int len;
            len = $urandom_range(16, 0);
            for (int i = 0; i < 16; i++) begin
                vin[i] = $urandom_range(15, 0);
                vw[i]  = $urandom_range(15, 0);
            end
            run_vec(len, $urandom_range(3, 0), $urandom_range(3, 0), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
